// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory port bundle for the load/store unit.
// The slave modport is the unit's view; the master modport is the CPU/memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-wide, registered-read data memory.
// Sub-word stores are read-modify-write; loads extract a little-endian lane and extend it.
module load_store_unit #(
  parameter int unsigned MEM_DEPTH_LOG2 = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t      state_reg, state_next;
  logic        write_reg;
  logic [1:0]  size_reg;
  logic        signed_reg;
  logic [1:0]  lane_reg;
  logic        err_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [31:0] rdata_reg;

  logic        accept;
  logic        size_bad, align_bad, range_bad, req_err;
  logic [31:0] word_idx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [3:0]  lane_en;
  logic [3:0][7:0] merged;

  assign accept = (state_reg == IDLE) && bus.req_valid;

  assign size_bad  = (bus.req_size == 2'b11);
  assign align_bad = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign range_bad = ((bus.req_addr >> (MEM_DEPTH_LOG2 + 2)) != 32'd0);
  assign req_err   = size_bad || align_bad || range_bad;

  assign word_idx = {{(32 - MEM_DEPTH_LOG2){1'b0}}, bus.req_addr[MEM_DEPTH_LOG2+1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_err)                                       state_next = RESP;
          else if (bus.req_write && bus.req_size == 2'b10)   state_next = WR;
          else                                               state_next = RD;
        end
      end
      RD:      state_next = CAP;
      CAP:     state_next = write_reg ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction for loads, from the word the memory presents during CAP.
  assign byte_sel = bus.mem_rdata[8*lane_reg +: 8];
  assign half_sel = bus.mem_rdata[16*lane_reg[1] +: 16];

  always_comb begin
    load_data = bus.mem_rdata;
    case (size_reg)
      2'b00:   load_data = {{24{signed_reg & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{signed_reg & half_sel[15]}}, half_sel};
      default: load_data = bus.mem_rdata;
    endcase
  end

  // Sub-word merge: mem_wdata_reg still holds the raw store data until CAP overwrites it.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_en[gi] = (size_reg == 2'b00) ? (lane_reg == 2'(gi))
                                               : (lane_reg[1] == 1'(gi / 2));
      assign merged[gi]  = !lane_en[gi]        ? bus.mem_rdata[8*gi +: 8] :
                           (size_reg == 2'b00) ? mem_wdata_reg[7:0]
                                               : mem_wdata_reg[8*(gi % 2) +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg     <= 1'b0;
      size_reg      <= 2'b00;
      signed_reg    <= 1'b0;
      lane_reg      <= 2'b00;
      err_reg       <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
      rdata_reg     <= 32'd0;
    end else if (accept) begin
      write_reg    <= bus.req_write;
      size_reg     <= bus.req_size;
      signed_reg   <= bus.req_signed;
      lane_reg     <= bus.req_addr[1:0];
      err_reg      <= req_err;
      mem_addr_reg <= word_idx;
      rdata_reg    <= 32'd0;
      if (bus.req_write && !req_err) mem_wdata_reg <= bus.req_wdata;
    end else if (state_reg == CAP) begin
      if (write_reg) mem_wdata_reg <= merged;
      else           rdata_reg     <= load_data;
    end
  end

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_err   = (state_reg == RESP) && err_reg;
  assign bus.resp_rdata = rdata_reg;
  assign bus.mem_we     = (state_reg == WR);
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read 256-word memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   wr4 = 0;
  logic [31:0] mem [256];
  logic [31:0] mem_rdata_q;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_DEPTH_LOG2(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (bus.mem_addr == 32'd4) wr4 <= wr4 + 1;
    end
    mem_rdata_q <= mem[bus.mem_addr[7:0]];
  end
  assign bus.mem_rdata = mem_rdata_q;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input bit wr, input bit [1:0] sz, input bit sg,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata, input bit exp_err);
    int lat;
    logic [31:0] rd;
    logic er;
    bit we_seen;
    lat = 0; rd = 32'hx; er = 1'bx; we_seen = 0;
    @(negedge clk);
    check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_write = wr; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.mem_we) we_seen = 1;
      if (bus.resp_valid) begin
        lat = k; rd = bus.resp_rdata; er = bus.resp_err;
      end
    end
    $display("[TB] %s: latency %0d rdata 0x%08h err %0d", tag, lat, rd, er);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, rd, exp_rdata);
    check({tag, " err"}, 32'(er), 32'(exp_err));
    if (exp_err) check({tag, " no mem_we"}, 32'(we_seen), 32'd0);
  endtask

  initial begin
    int first_resp, second_resp;
    logic [31:0] first_data, second_data;
    logic [8:1] rdy;

    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_signed = 0;
    bus.req_addr = 0; bus.req_wdata = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst mem_we", 32'(bus.mem_we), 32'd0);
    check("rst resp_err", 32'(bus.resp_err), 32'd0);
    check("rst resp_rdata", bus.resp_rdata, 32'd0);
    check("rst mem_addr", bus.mem_addr, 32'd0);
    check("rst mem_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst release ready", 32'(bus.req_ready), 32'd1);

    // Word store / word load
    do_req("st_w 0x10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 0);
    check("mem4 after st_w", mem[4], 32'hDEADBEEF);
    check("mem4 write count 1", 32'(wr4), 32'd1);
    do_req("ld_w 0x10", 0, 2'b10, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0);
    check("mem_addr held", bus.mem_addr, 32'd4);
    check("mem4 write count still 1", 32'(wr4), 32'd1);

    // Byte store and byte loads
    do_req("st_b 0x11", 1, 2'b00, 0, 32'h11, 32'h000000A5, 4, 32'h0, 0);
    check("mem4 after st_b", mem[4], 32'hDEADA5EF);
    do_req("ld_b s 0x11", 0, 2'b00, 1, 32'h11, 32'h0, 3, 32'hFFFFFFA5, 0);
    do_req("ld_b u 0x11", 0, 2'b00, 0, 32'h11, 32'h0, 3, 32'h000000A5, 0);

    // Halfword loads, halfword store, low-lane byte load
    do_req("ld_h s 0x12", 0, 2'b01, 1, 32'h12, 32'h0, 3, 32'hFFFFDEAD, 0);
    do_req("ld_h u 0x12", 0, 2'b01, 0, 32'h12, 32'h0, 3, 32'h0000DEAD, 0);
    do_req("st_h 0x12", 1, 2'b01, 0, 32'h12, 32'hFFFF1234, 4, 32'h0, 0);
    check("mem4 after st_h", mem[4], 32'h1234A5EF);
    do_req("ld_b s 0x10", 0, 2'b00, 1, 32'h10, 32'h0, 3, 32'hFFFFFFEF, 0);

    // Top of memory
    do_req("st_w 0x3FC", 1, 2'b10, 0, 32'h3FC, 32'h0BADF00D, 2, 32'h0, 0);
    check("mem255", mem[255], 32'h0BADF00D);
    do_req("ld_w 0x3FC", 0, 2'b10, 0, 32'h3FC, 32'h0, 3, 32'h0BADF00D, 0);

    // Rejected accesses
    do_req("err ld_w 0x13", 0, 2'b10, 0, 32'h13, 32'h0, 1, 32'h0, 1);
    do_req("err ld_h 0x11", 0, 2'b01, 1, 32'h11, 32'h0, 1, 32'h0, 1);
    do_req("err st_w 0x400", 1, 2'b10, 0, 32'h400, 32'h12345678, 1, 32'h0, 1);
    do_req("err size11 0x10", 1, 2'b11, 0, 32'h10, 32'h55555555, 1, 32'h0, 1);
    check("mem4 after errors", mem[4], 32'h1234A5EF);
    check("mem0 untouched", mem[0] === 32'h12345678 ? 32'd1 : 32'd0, 32'd0);

    // Reset during the write phase of a byte store
    @(negedge clk);
    bus.req_write = 1; bus.req_size = 2'b00; bus.req_signed = 0;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0000005A; bus.req_valid = 1;
    @(posedge clk);
    #1 bus.req_valid = 0;
    repeat (3) @(negedge clk);
    check("rstmid mem_we in WR", 32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid mem_we async low", 32'(bus.mem_we), 32'd0);
    check("rstmid mem_wdata", bus.mem_wdata, 32'd0);
    check("rstmid mem_addr", bus.mem_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset mid-store: mem4 0x%08h ready %0d", mem[4], bus.req_ready);
    check("rstmid ready after release", 32'(bus.req_ready), 32'd1);
    check("rstmid mem4 unchanged", mem[4], 32'h1234A5EF);
    check("rstmid write count", 32'(wr4), 32'd3);

    // req_valid held high across two word loads
    first_resp = 0; second_resp = 0; first_data = 0; second_data = 0; rdy = '0;
    bus.req_write = 0; bus.req_size = 2'b10; bus.req_signed = 0;
    bus.req_addr = 32'h10; bus.req_valid = 1;
    @(posedge clk);
    #1 bus.req_addr = 32'h3FC;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rdy[k] = bus.req_ready;
      if (bus.resp_valid) begin
        if (first_resp == 0) begin first_resp = k; first_data = bus.resp_rdata; end
        else begin second_resp = k; second_data = bus.resp_rdata; end
      end
      if (k == 5) bus.req_valid = 0;
    end
    $display("[TB] back-to-back: resp cycles %0d,%0d ready %b", first_resp, second_resp, rdy);
    check("b2b ready c1-4", 32'(rdy[4:1]), 32'b1000);
    check("b2b ready c8", 32'(rdy[8]), 32'd1);
    check("b2b first resp cycle", 32'(first_resp), 32'd3);
    check("b2b first rdata", first_data, 32'h1234A5EF);
    check("b2b second resp cycle", 32'(second_resp), 32'd7);
    check("b2b second rdata", second_data, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL provide parameter: MEM_DEPTH_LOG2, default 8, log2 of data-memory depth in 32-bit words (256 words).
REQ-002 SHALL provide ports, one per line:
  clk  input  1  rising-edge clock shared with data memory
  rst_n  input  1  asynchronous active-low reset
  req_valid  input  1  access request present
  req_ready  output  1  unit can accept a request
  req_write  input  1  1=store, 0=load
  req_size  input  2  00=byte, 01=halfword, 10=word, 11=illegal
  req_signed  input  1  loads: 1=sign-extend, 0=zero-extend
  req_addr  input  32  byte address from ALU
  req_wdata  input  32  store data from register file (low bits used for sub-word)
  resp_valid  output  1  one-cycle completion pulse
  resp_rdata  output  32  load result, extended
  resp_err  output  1  access rejected (misaligned/out of range/illegal size)
  mem_we  output  1  data-memory write enable
  mem_addr  output  32  data-memory word index
  mem_wdata  output  32  data-memory write word
  mem_rdata  input  32  data-memory read word, registered by memory (valid the cycle after mem_addr is sampled)
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL implement FSM states IDLE, RD, CAP, WR, RESP; req_ready=1 only in IDLE.
REQ-005 Request accepted on rising edge with req_valid=1 in IDLE; all req_* fields registered at that edge and ignored afterwards.
REQ-006 Error on accept if: req_size=11; halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:MEM_DEPTH_LOG2+2]!=0.
REQ-007 Transitions from IDLE on accept: error->RESP; word store->WR; any load or sub-word store->RD.
REQ-008 RD->CAP unconditionally; CAP->RESP for loads, CAP->WR for sub-word stores; WR->RESP; RESP->IDLE.
REQ-009 mem_addr SHALL be registered, zero-extended addr[MEM_DEPTH_LOG2+1:2], updated at accept, held otherwise.
REQ-010 mem_we SHALL be 1 only in WR; never asserted for an erroring request.
REQ-011 In CAP, mem_rdata captured; loads: little-endian lane (byte lane=addr[1:0], half lane=addr[1]) extracted and extended per req_signed into resp_rdata; word loads pass through.
REQ-012 Sub-word store: mem_wdata = captured word with selected lane replaced by req_wdata[7:0] or [15:0]; word store: mem_wdata=req_wdata.
REQ-013 resp_valid=1 exactly one cycle (RESP); resp_rdata/resp_err valid that cycle; resp_rdata=0 for stores and errors; resp_err=0 for non-errors.
REQ-014 Latency from accept edge, resp_valid high in cycle: error 1, word store 2, load 3, sub-word store 4.
REQ-015 req_valid held high while busy SHALL NOT be accepted until next IDLE; no back-to-back overlap.

Reset
REQ-016 rst_n low SHALL immediately force IDLE, mem_we=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, req_ready=1 on release.
REQ-017 Reset mid-operation SHALL abandon the access; a pending WR SHALL NOT write memory.

Verification
REQ-018 Word store 0xDEADBEEF @0x10, then word load @0x10 -> store resp_valid cycle 2, load resp_valid cycle 3, resp_rdata=0xDEADBEEF, mem word 4 written once.
REQ-019 Byte store 0x000000A5 @0x11 over 0xDEADBEEF -> mem word 4=0xDEADA5EF, resp cycle 4; signed byte load @0x11 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
REQ-020 Signed halfword load @0x12 of 0xDEADA5EF -> 0xFFFFDEAD; unsigned -> 0x0000DEAD.
REQ-021 Word load @0x13, halfword @0x11, word @0x400, size=11 -> each resp_valid cycle 1, resp_err=1, resp_rdata=0, mem_we never 1.
REQ-022 rst_n low during WR of byte store -> mem_we falls asynchronously, memory word unchanged, req_ready=1 first cycle after release.
REQ-023 req_valid held high for two loads -> req_ready low cycles 1-3, second accepted at first IDLE edge, second resp_valid 4 cycles after first.
